// File: rtl/serial_frame_shifter.sv
// Multi-lane serial shifter for word-latched display chains: frames are double-buffered,
// shifted out one bit per ena tick, with a shared latch strobe after every word.
module serial_frame_shifter #(
    parameter int NUM_DIGITS   = 6,
    parameter int DIGIT_WIDTH  = 8,
    parameter int NUM_CHANNELS = 2,
    parameter int LATCH_WIDTH  = 1,
    parameter int LSB_FIRST    = 0
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               ena,
    input  logic                                               frame_valid,
    output logic                                               frame_ready,
    input  logic [NUM_CHANNELS-1:0][NUM_DIGITS*DIGIT_WIDTH-1:0] frame_data,
    output logic [NUM_CHANNELS-1:0]                            ser_out,
    output logic                                               latch_out,
    output logic                                               busy,
    output logic                                               frame_done
);

    localparam int FW  = NUM_DIGITS * DIGIT_WIDTH;
    localparam int BCW = $clog2(DIGIT_WIDTH + 1);
    localparam int WCW = $clog2(NUM_DIGITS + 1);
    localparam int LCW = $clog2(LATCH_WIDTH + 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(DIGIT_WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST  = WCW'(NUM_DIGITS - 1);
    localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

    state_t         state_reg, state_next;
    logic           hold_full_reg;
    logic [BCW-1:0] bit_cnt_reg;
    logic [WCW-1:0] word_cnt_reg;
    logic [LCW-1:0] latch_cnt_reg;
    logic           latch_out_reg;
    logic           frame_done_reg;

    logic [FW-1:0]  hold_reg  [NUM_CHANNELS];
    logic [FW-1:0]  shift_reg [NUM_CHANNELS];
    logic           ser_reg   [NUM_CHANNELS];

    logic accept;
    logic load;
    logic bit_adv;
    logic word_adv;
    logic latch_start;
    logic latch_tick;
    logic latch_end;
    logic frame_end;
    logic go_idle;

    assign accept      = frame_valid && !hold_full_reg;
    assign frame_ready = !hold_full_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign latch_out   = latch_out_reg;
    assign frame_done  = frame_done_reg;
    assign go_idle     = frame_end && !load;

    always_comb begin
        state_next  = state_reg;
        load        = 1'b0;
        bit_adv     = 1'b0;
        word_adv    = 1'b0;
        latch_start = 1'b0;
        latch_tick  = 1'b0;
        latch_end   = 1'b0;
        frame_end   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (hold_full_reg) begin
                    load       = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ena) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        latch_start = 1'b1;
                        state_next  = ST_LATCH;
                    end else begin
                        bit_adv = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (ena) begin
                    latch_tick = 1'b1;
                    if (latch_cnt_reg == LATCH_LAST) begin
                        latch_end = 1'b1;
                        if (word_cnt_reg == WORD_LAST) begin
                            frame_end = 1'b1;
                            // Back-to-back frames: the held frame loads on the final latch tick
                            if (hold_full_reg) begin
                                load       = 1'b1;
                                state_next = ST_SHIFT;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end else begin
                            word_adv   = 1'b1;
                            state_next = ST_SHIFT;
                        end
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hold_full_reg  <= 1'b0;
            bit_cnt_reg    <= '0;
            word_cnt_reg   <= '0;
            latch_cnt_reg  <= '0;
            latch_out_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= frame_end;

            if (accept) begin
                hold_full_reg <= 1'b1;
            end else if (load) begin
                hold_full_reg <= 1'b0;
            end

            if (bit_adv) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end else if (latch_start || load) begin
                bit_cnt_reg <= '0;
            end

            if (word_adv) begin
                word_cnt_reg <= word_cnt_reg + 1'b1;
            end else if (frame_end) begin
                word_cnt_reg <= '0;
            end

            if (latch_end) begin
                latch_cnt_reg <= '0;
            end else if (latch_tick) begin
                latch_cnt_reg <= latch_cnt_reg + 1'b1;
            end

            if (latch_start) begin
                latch_out_reg <= 1'b1;
            end else if (latch_end) begin
                latch_out_reg <= 1'b0;
            end
        end
    end

    // ser_reg always shows the bit that the next SHIFT tick consumes; shift_reg holds the rest
    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (accept) begin
                    hold_reg[gi] <= frame_data[gi];
                end
            end

            if (LSB_FIRST != 0) begin : g_lsb
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        shift_reg[gi] <= '0;
                        ser_reg[gi]   <= 1'b0;
                    end else if (load) begin
                        ser_reg[gi]   <= hold_reg[gi][0];
                        shift_reg[gi] <= hold_reg[gi] >> 1;
                    end else if (bit_adv || word_adv) begin
                        ser_reg[gi]   <= shift_reg[gi][0];
                        shift_reg[gi] <= shift_reg[gi] >> 1;
                    end else if (go_idle) begin
                        ser_reg[gi]   <= 1'b0;
                    end
                end
            end else begin : g_msb
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        shift_reg[gi] <= '0;
                        ser_reg[gi]   <= 1'b0;
                    end else if (load) begin
                        ser_reg[gi]   <= hold_reg[gi][FW-1];
                        shift_reg[gi] <= hold_reg[gi] << 1;
                    end else if (bit_adv || word_adv) begin
                        ser_reg[gi]   <= shift_reg[gi][FW-1];
                        shift_reg[gi] <= shift_reg[gi] << 1;
                    end else if (go_idle) begin
                        ser_reg[gi]   <= 1'b0;
                    end
                end
            end

            assign ser_out[gi] = ser_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_serial_frame_shifter.sv
// Scoreboard bench: stimulus queues expected words/frames, negedge monitors act as a
// shift-register receiver and compare each latched word and each finished frame.
module tb_serial_frame_shifter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance, default parameters
    logic             rst_a, ena_a, valid_a, ready_a, latch_a, busy_a, done_a;
    logic [1:0][47:0] data_a;
    logic [1:0]       ser_a;

    // LSB-first instance and short-frame instance share reset/valid/ena
    logic             rst_bc, ena_bc, valid_bc;
    logic             ready_b, latch_b, busy_b, done_b;
    logic [1:0][47:0] data_b;
    logic [1:0]       ser_b;
    logic             ready_c, latch_c, busy_c, done_c;
    logic [1:0][7:0]  data_c;
    logic [1:0]       ser_c;

    serial_frame_shifter dut_a (
        .clk(clk), .rst(rst_a), .ena(ena_a), .frame_valid(valid_a), .frame_ready(ready_a),
        .frame_data(data_a), .ser_out(ser_a), .latch_out(latch_a), .busy(busy_a),
        .frame_done(done_a)
    );

    serial_frame_shifter #(.LSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst_bc), .ena(ena_bc), .frame_valid(valid_bc), .frame_ready(ready_b),
        .frame_data(data_b), .ser_out(ser_b), .latch_out(latch_b), .busy(busy_b),
        .frame_done(done_b)
    );

    serial_frame_shifter #(.NUM_DIGITS(2), .DIGIT_WIDTH(4), .LATCH_WIDTH(3)) dut_c (
        .clk(clk), .rst(rst_bc), .ena(ena_bc), .frame_valid(valid_bc), .frame_ready(ready_c),
        .frame_data(data_c), .ser_out(ser_c), .latch_out(latch_c), .busy(busy_c),
        .frame_done(done_c)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] word_q  [$];   // {lane1, lane0} per word, display order
    int          per_q   [$];   // expected busy cycles per frame
    logic [95:0] exp_b_q [$];   // {lane1, lane0} captured-stream vectors
    logic [15:0] exp_c_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur (expected it) at %0t", name, $time);
    endtask

    // ---------------- monitor: main instance ----------------
    logic [7:0]  rx0, rx1;
    logic [15:0] exp_w;
    int          cyc_a, nlat_a, wnum;
    logic        prev_latch_a, prev_busy_a, prev_ena_a;
    logic [1:0]  prev_ser_a;

    always @(negedge clk) begin
        if (rst_a) begin
            rx0 = '0; rx1 = '0; cyc_a = 0; nlat_a = 0;
            prev_latch_a = 1'b0; prev_busy_a = 1'b0; prev_ena_a = 1'b1; prev_ser_a = '0;
            word_q.delete();
            per_q.delete();
        end else begin
            if (done_a) begin
                if (per_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame_done: got frame_done=1 expected 0 at %0t", $time);
                end else begin
                    int p;
                    p = per_q.pop_front();
                    chk("frame_period", cyc_a, p);
                    chk("latches_per_frame", nlat_a, 6);
                    $display("frame done: %0d cycles, %0d latches", cyc_a, nlat_a);
                end
                cyc_a = 0; nlat_a = 0;
            end
            if (busy_a) cyc_a++;
            if (prev_busy_a && busy_a && !prev_ena_a) begin
                chk("ser_frozen", ser_a, prev_ser_a);
                chk("latch_frozen", latch_a, prev_latch_a);
            end
            if (latch_a && !prev_latch_a) begin
                nlat_a++;
                if (word_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_latch: got latch with no word queued at %0t", $time);
                end else begin
                    exp_w = word_q.pop_front();
                    chk("word_lane0", rx0, exp_w[7:0]);
                    chk("word_lane1", rx1, exp_w[15:8]);
                    $display("word %0d: lane0=%02h lane1=%02h", wnum, rx0, rx1);
                    wnum++;
                end
            end
            if (ena_a && busy_a && !latch_a) begin
                rx0 = {rx0[6:0], ser_a[0]};
                rx1 = {rx1[6:0], ser_a[1]};
            end
            prev_latch_a = latch_a;
            prev_busy_a  = busy_a;
            prev_ena_a   = ena_a;
            prev_ser_a   = ser_a;
        end
    end

    // ---------------- monitor: LSB-first and short-frame instances ----------------
    logic [47:0] cb0, cb1;
    logic [7:0]  cc0, cc1;
    logic [95:0] exp_b;
    logic [15:0] exp_c;
    int          cyc_c, lhi_c, nlat_c;
    logic        prev_latch_c;

    always @(negedge clk) begin
        if (rst_bc) begin
            cb0 = '0; cb1 = '0; cc0 = '0; cc1 = '0;
            cyc_c = 0; lhi_c = 0; nlat_c = 0; prev_latch_c = 1'b0;
        end else begin
            if (done_b) begin
                if (exp_b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_b: got frame_done=1 expected 0 at %0t", $time);
                end else begin
                    exp_b = exp_b_q.pop_front();
                    chk("lsb_stream_lane0", cb0, exp_b[47:0]);
                    chk("lsb_stream_lane1", cb1, exp_b[95:48]);
                    $display("lsb frame: lane0=%012h lane1=%012h", cb0, cb1);
                end
                cb0 = '0; cb1 = '0;
            end
            if (busy_b && !latch_b && ena_bc) begin
                cb0 = {cb0[46:0], ser_b[0]};
                cb1 = {cb1[46:0], ser_b[1]};
            end

            if (done_c) begin
                if (exp_c_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done_c: got frame_done=1 expected 0 at %0t", $time);
                end else begin
                    exp_c = exp_c_q.pop_front();
                    chk("short_stream_lane0", cc0, exp_c[7:0]);
                    chk("short_stream_lane1", cc1, exp_c[15:8]);
                    chk("short_frame_period", cyc_c, 14);
                    chk("short_latches", nlat_c, 2);
                    $display("short frame: lane0=%02h lane1=%02h %0d cycles", cc0, cc1, cyc_c);
                end
                cyc_c = 0; nlat_c = 0;
            end
            if (busy_c) cyc_c++;
            if (latch_c) lhi_c++;
            if (!latch_c && prev_latch_c) begin
                chk("short_latch_width", lhi_c, 3);
                lhi_c = 0;
            end
            if (latch_c && !prev_latch_c) nlat_c++;
            if (busy_c && !latch_c && ena_bc) begin
                cc0 = {cc0[6:0], ser_c[0]};
                cc1 = {cc1[6:0], ser_c[1]};
            end
            prev_latch_c = latch_c;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic [47:0] l0, input logic [47:0] l1, input int period);
        int n;
        n = 0;
        while (!ready_a && n < 500) begin
            step();
            n++;
        end
        if (!ready_a) fail_now("offer_ready_timeout");
        for (int w = 5; w >= 0; w--) word_q.push_back({l1[w*8 +: 8], l0[w*8 +: 8]});
        per_q.push_back(period);
        valid_a   = 1'b1;
        data_a[0] = l0;
        data_a[1] = l1;
        step();
        valid_a   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_a || !ready_a) && n < 2000) begin
            step();
            n++;
        end
        if (busy_a || !ready_a) fail_now("idle_timeout");
        step();
        step();
    endtask

    initial begin
        int n;
        rst_a = 1'b1; rst_bc = 1'b1; ena_a = 1'b1; ena_bc = 1'b1;
        valid_a = 1'b0; valid_bc = 1'b0;
        data_a = '0; data_b = '0; data_c = '0;
        wnum = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ser", ser_a, 2'b00);
        chk("reset_latch", latch_a, 1'b0);
        chk("reset_busy", busy_a, 1'b0);
        chk("reset_done", done_a, 1'b0);
        chk("reset_ready", ready_a, 1'b1);
        @(posedge clk);
        #3;
        rst_a = 1'b0; rst_bc = 1'b0;
        step();
        step();
        chk("idle_ser", ser_a, 2'b00);
        chk("idle_ready", ready_a, 1'b1);

        // back-to-back frames, second offered while first shifts
        offer_a(48'h20_10_08_04_02_01, 48'h41_49_99_0D_25_9F, 54);
        step();
        chk("busy_after_load", busy_a, 1'b1);
        repeat (5) step();
        chk("ready_while_shifting", ready_a, 1'b1);
        offer_a(48'h80_40_20_10_08_04, 48'h63_C1_11_09_01_1F, 54);
        chk("ready_hold_full", ready_a, 1'b0);
        n = 0;
        @(negedge clk);
        while (!done_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done_a) begin
            fail_now("first_frame_done_timeout");
        end else begin
            chk("b2b_busy", busy_a, 1'b1);
            chk("b2b_latch", latch_a, 1'b0);
            chk("b2b_ready", ready_a, 1'b1);
            chk("b2b_first_bits", ser_a, 2'b01);
        end
        step();
        wait_idle();

        // ena toggling 1,0: accept on an ena=0 edge, load on ena=1, ticks on even edges
        ena_a = 1'b0;
        offer_a(48'hAA_55_0F_F0_81_7E, 48'h12_34_56_78_9A_BC, 108);
        ena_a = 1'b1;
        step();
        ena_a = 1'b0;
        for (int k = 0; k < 116; k++) begin
            step();
            ena_a = ~ena_a;
        end
        ena_a = 1'b1;
        wait_idle();

        // reset mid-frame with the holding buffer full
        offer_a(48'h11_22_33_44_55_66, 48'hFF_00_FF_00_FF_00, 54);
        step();
        offer_a(48'hDE_AD_BE_EF_00_01, 48'h01_02_03_04_05_06, 54);
        chk("hold_full_before_rst", ready_a, 1'b0);
        repeat (20) step();
        #2;
        rst_a = 1'b1;
        #1;
        chk("rst_async_ser", ser_a, 2'b00);
        chk("rst_async_latch", latch_a, 1'b0);
        chk("rst_async_busy", busy_a, 1'b0);
        chk("rst_async_done", done_a, 1'b0);
        chk("rst_async_ready", ready_a, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst_a = 1'b0;
        repeat (4) step();
        chk("post_rst_busy", busy_a, 1'b0);
        chk("post_rst_ready", ready_a, 1'b1);
        offer_a(48'h5A_A5_C3_3C_E7_18, 48'h01_03_07_0F_1F_3F, 54);
        wait_idle();

        // LSB-first and short-frame instances
        exp_b_q.push_back({48'h0F00_0000_0000, 48'h8000_0000_0000});
        exp_c_q.push_back({8'h3C, 8'hA5});
        data_b[0] = 48'h00_00_00_00_00_01;
        data_b[1] = 48'h00_00_00_00_00_F0;
        data_c[0] = 8'hA5;
        data_c[1] = 8'h3C;
        valid_bc  = 1'b1;
        step();
        valid_bc  = 1'b0;
        n = 0;
        while ((busy_b || busy_c || !ready_b || !ready_c) && n < 500) begin
            step();
            n++;
        end
        if (busy_b || busy_c) fail_now("bc_idle_timeout");
        repeat (3) step();

        chk("queues_drained", word_q.size() + per_q.size() + exp_b_q.size() + exp_c_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_frame_shifter.md
SERIAL_FRAME_SHIFTER -- requirements
Module: serial_frame_shifter

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 6, meaning words (display digits) per frame.
REQ-002 The block SHALL have parameter DIGIT_WIDTH, default 8, meaning bits per word.
REQ-003 The block SHALL have parameter NUM_CHANNELS, default 2, meaning parallel serial lanes sharing one latch.
REQ-004 The block SHALL have parameter LATCH_WIDTH, default 1, meaning ena ticks latch_out stays high per word.
REQ-005 The block SHALL have parameter LSB_FIRST, default 0, meaning 0 = frame MSB first, 1 = frame bit 0 first.
REQ-006 Ports SHALL be: clk  in  1  single clock, all state on rising edge.
REQ-007 Ports SHALL be: rst  in  1  asynchronous, active-high reset.
REQ-008 Ports SHALL be: ena  in  1  bit-tick enable; shifting and latch timing advance only on edges with ena=1.
REQ-009 Ports SHALL be: frame_valid  in  1  upstream frame offered.
REQ-010 Ports SHALL be: frame_ready  out  1  holding buffer empty.
REQ-011 Ports SHALL be: frame_data  in  NUM_CHANNELS x (NUM_DIGITS*DIGIT_WIDTH)  one frame per lane.
REQ-012 Ports SHALL be: ser_out  out  NUM_CHANNELS  registered serial data per lane.
REQ-013 Ports SHALL be: latch_out  out  1  registered word-latch strobe, common to all lanes.
REQ-014 Ports SHALL be: busy  out  1  high in SHIFT or LATCH.
REQ-015 Ports SHALL be: frame_done  out  1  one-clk pulse when a frame's last latch ends.

Function
REQ-016 Frame accept: frame_valid&&frame_ready on a clk edge (ena ignored) SHALL copy frame_data into a 1-deep holding buffer; frame_ready = ~hold_full, combinational from register only.
REQ-017 States SHALL be IDLE, SHIFT, LATCH; IDLE with hold_full SHALL on the next clk edge (ena ignored) move hold into the active shift register, clear hold_full, enter SHIFT.
REQ-018 On entry to SHIFT each ser_out lane SHALL already present the first stream bit: bit [NUM_DIGITS*DIGIT_WIDTH-1] if LSB_FIRST=0, bit [0] if LSB_FIRST=1.
REQ-019 In SHIFT each ena=1 edge SHALL consume one bit; after the DIGIT_WIDTH-th tick of a word the state SHALL go to LATCH with latch_out=1 and ser_out holding the word's last bit.
REQ-020 LATCH SHALL last exactly LATCH_WIDTH ena ticks; on its final tick latch_out SHALL drop and, if words remain, SHIFT SHALL resume presenting the next word's first bit.
REQ-021 After the NUM_DIGITS-th latch, frame_done SHALL pulse for one clk; if hold_full the next frame SHALL load on that same edge (no gap ticks), else state SHALL return to IDLE.
REQ-022 With ena held 1, one frame SHALL occupy exactly NUM_DIGITS*(DIGIT_WIDTH+LATCH_WIDTH) clk cycles in SHIFT/LATCH.
REQ-023 ena=0 SHALL freeze state, counters, ser_out and latch_out; accept/transfer per REQ-016/017 still proceed.
REQ-024 Frame acceptance during SHIFT/LATCH SHALL be allowed and SHALL NOT disturb the active frame.
REQ-025 Bit counter width SHALL be $clog2(DIGIT_WIDTH+1); word counter $clog2(NUM_DIGITS+1); no wrap beyond terminal counts.
REQ-026 In IDLE ser_out SHALL be all 0 and latch_out 0.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, hold_full=0, counters 0, ser_out=0, latch_out=0, busy=0, frame_done=0; frame_ready=1.
REQ-028 rst asserted mid-frame SHALL abandon the active and held frame with no further latch pulse; first frame after release SHALL start from bit 0 of word 0.

Verification
REQ-029 Defaults, ena=1, lane0 48'h20_10_08_04_02_01, lane1 48'h41_49_99_0D_25_9F accepted -> lane1 first 8 bits 0,1,0,0,0,0,0,1; latch_out high 1 cycle after each 8 bits; 6 latches; frame_done 54 cycles after SHIFT entry.
REQ-030 Second frame lane1 48'h63_C1_11_09_01_1F offered while first shifting -> accepted immediately, frame_ready=0 until transfer, first bit of 0x63 follows last latch with zero gap.
REQ-031 ena toggling 1,0 each cycle -> identical bit/latch sequence at half rate, 108 cycles per frame, ser_out stable across ena=0 cycles.
REQ-032 LSB_FIRST=1, lane0 48'h00_00_00_00_00_01 -> first ser_out bit 1, remaining 47 bits 0.
REQ-033 LATCH_WIDTH=3, NUM_DIGITS=2, DIGIT_WIDTH=4 -> latch_out high 3 ticks after every 4 bits, frame 14 cycles.
REQ-034 rst pulsed at bit 20 of a frame with hold full -> outputs zero asynchronously, frame_ready=1, no frame_done, next accepted frame shifts from its first bit.
